tt_sweeper: RTL

//  Sequential truth-table sweeper for a combinational N_IN-input, 1-output function under test (FUT).

---
 rtl/tt_sweeper_if.sv | 30 +++
 rtl/tt_sweeper.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/tt_sweeper_if.sv
// Bus between the truth-table sweeper and its environment: control
// handshake in, FUT stimulus out, FUT response in, results out.
interface tt_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int L = 1 << N_IN;

  logic              start;
  logic              abort;
  logic              f_in;
  logic [N_IN-1:0]   stim;
  logic              busy;
  logic              done;
  logic [L-1:0]      table_out;
  logic [N_IN:0]     err_count;
  logic [N_IN-1:0]   first_err_idx;
  logic              pass;

  // Environment side: issues commands, closes the loop through the FUT.
  modport master (
    output start, abort, f_in,
    input  stim, busy, done, table_out, err_count, first_err_idx, pass
  );

  // Sweeper side.
  modport slave (
    input  start, abort, f_in,
    output stim, busy, done, table_out, err_count, first_err_idx, pass
  );
endinterface

// File: rtl/tt_sweeper.sv
// Sequential truth-table sweeper. Walks stim through 0..L-1, lets the
// FUT settle for SETTLE cycles per vector, samples f_in into table_out
// and scores the captured table against EXPECTED on the fly.
module tt_sweeper #(
  parameter int                      N_IN     = 3,
  parameter int                      SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED = 8'hD7
) (
  input  logic        clk,
  input  logic        rst_n,
  tt_sweeper_if.slave bus
);

  localparam int L  = 1 << N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0]   CNT_INIT = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
  localparam logic [CW-1:0]   CNT_ONE  = 1;
  localparam logic [N_IN-1:0] IDX_ONE  = 1;
  localparam logic [N_IN-1:0] IDX_LAST = '1;
  localparam logic [N_IN:0]   ERR_ONE  = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state_q,  state_d;
  logic [CW-1:0]     cnt_q,    cnt_d;
  // stim doubles as the sweep index: it equals idx during a sweep and is 0 otherwise.
  logic [N_IN-1:0]   stim_q,   stim_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic [L-1:0]      table_q,  table_d;
  logic [N_IN:0]     errc_q,   errc_d;
  logic [N_IN-1:0]   ferr_q,   ferr_d;
  logic              pass_q,   pass_d;
  logic              mism;

  // State and result registers; synchronous reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      errc_q  <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      errc_q  <= errc_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
    end
  end

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so the ports come straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    errc_d  = errc_q;
    ferr_d  = ferr_q;
    pass_d  = pass_q;
    mism    = 1'b0;

    if (bus.abort && (state_q == S_SETTLE || state_q == S_SAMPLE)) begin
      // Cancelled sweep leaves nothing behind that could be mistaken for a result.
      state_d = S_IDLE;
      cnt_d   = '0;
      stim_d  = '0;
      busy_d  = 1'b0;
      table_d = '0;
      errc_d  = '0;
      ferr_d  = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            table_d = '0;
            errc_d  = '0;
            ferr_d  = '0;
            pass_d  = 1'b0;
            stim_d  = '0;
            busy_d  = 1'b1;
            if (SETTLE == 0) begin
              state_d = S_SAMPLE;
            end else begin
              state_d = S_SETTLE;
              cnt_d   = CNT_INIT;
            end
          end
        end

        S_SETTLE: begin
          if (cnt_q == '0) state_d = S_SAMPLE;
          else             cnt_d   = cnt_q - CNT_ONE;
        end

        S_SAMPLE: begin
          table_d[stim_q] = bus.f_in;
          mism            = (bus.f_in != EXPECTED[stim_q]);
          if (mism) begin
            errc_d = errc_q + ERR_ONE;
            // Only the lowest failing vector is kept; sweep order is ascending.
            if (errc_q == '0) ferr_d = stim_q;
          end
          if (stim_q == IDX_LAST) begin
            state_d = S_DONE;
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (errc_d == '0);
          end else begin
            stim_d = stim_q + IDX_ONE;
            if (SETTLE == 0) begin
              state_d = S_SAMPLE;
            end else begin
              state_d = S_SETTLE;
              cnt_d   = CNT_INIT;
            end
          end
        end

        S_DONE: begin
          // One-cycle pause so start held high cannot be taken during the pulse.
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.stim          = stim_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.table_out     = table_q;
  assign bus.err_count     = errc_q;
  assign bus.first_err_idx = ferr_q;
  assign bus.pass          = pass_q;

endmodule
